// File: rtl/fft16_bitrev_reorder_if.sv
// Stream bundle for the bit-reverse reorder buffer: sample input side (s_*) and
// natural-order output side (m_*).
interface fft16_bitrev_reorder_if #(
    parameter int unsigned N = 16
);
    logic                s_valid;
    logic                s_ready;
    logic signed [N-1:0] s_r;
    logic signed [N-1:0] s_i;
    logic                m_valid;
    logic                m_ready;
    logic signed [N-1:0] m_r;
    logic signed [N-1:0] m_i;
    logic                m_last;

    modport slave (
        input  s_valid, s_r, s_i, m_ready,
        output s_ready, m_valid, m_r, m_i, m_last
    );

    modport master (
        output s_valid, s_r, s_i, m_ready,
        input  s_ready, m_valid, m_r, m_i, m_last
    );
endinterface

// File: rtl/fft16_bitrev_reorder.sv
// Ping-pong reorder buffer: accepts 16-sample frames in bit-reversed order and
// emits them in natural order, one bank filling while the other drains.
module fft16_bitrev_reorder #(
    parameter int unsigned N = 16,
    parameter int unsigned Q = 8
) (
    input logic                   clk,
    input logic                   rst_n,
    fft16_bitrev_reorder_if.slave bus
);

    logic [3:0]     wcnt_q;
    logic [3:0]     rcnt_q;
    logic           wbank_q;
    logic           rbank_q;
    logic [1:0]     full_q;
    logic [1:0]     full_d;
    logic [2*N-1:0] mem_q [2][16];

    logic           s_ready;
    logic           m_valid;
    logic           in_xfer;
    logic           out_xfer;
    logic           in_end;
    logic           out_end;
    logic [3:0]     waddr;
    logic [2*N-1:0] rdata;

    // Q only describes the number format; the buffer moves raw bits.
    logic [31:0]    unused_q;
    assign unused_q = 32'(Q);

    function automatic logic [3:0] bitrev4(input logic [3:0] b);
        return {b[0], b[1], b[2], b[3]};
    endfunction

    assign s_ready  = ~full_q[wbank_q];
    assign m_valid  = full_q[rbank_q];
    assign in_xfer  = bus.s_valid & s_ready;
    assign out_xfer = m_valid & bus.m_ready;
    assign in_end   = in_xfer & (wcnt_q == 4'd15);
    assign out_end  = out_xfer & (rcnt_q == 4'd15);
    assign waddr    = bitrev4(wcnt_q);
    assign rdata    = mem_q[rbank_q][rcnt_q];

    assign bus.s_ready = s_ready;
    assign bus.m_valid = m_valid;
    assign bus.m_r     = rdata[2*N-1:N];
    assign bus.m_i     = rdata[N-1:0];
    assign bus.m_last  = m_valid & (rcnt_q == 4'd15);

    // End-of-write and end-of-read always target different banks, so both apply.
    always_comb begin
        full_d = full_q;
        if (in_end) begin
            full_d[wbank_q] = 1'b1;
        end
        if (out_end) begin
            full_d[rbank_q] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wcnt_q  <= 4'd0;
            rcnt_q  <= 4'd0;
            wbank_q <= 1'b0;
            rbank_q <= 1'b0;
            full_q  <= 2'b00;
        end else begin
            full_q <= full_d;
            if (in_xfer) begin
                wcnt_q <= wcnt_q + 4'd1;
            end
            if (in_end) begin
                wbank_q <= ~wbank_q;
            end
            if (out_xfer) begin
                rcnt_q <= rcnt_q + 4'd1;
            end
            if (out_end) begin
                rbank_q <= ~rbank_q;
            end
        end
    end

    // Storage is deliberately not reset; m_valid gates its visibility.
    always_ff @(posedge clk) begin
        if (in_xfer) begin
            mem_q[wbank_q][waddr] <= {bus.s_r, bus.s_i};
        end
    end

endmodule

// File: tb/tb_fft16_bitrev_reorder.sv
// Self-checking bench for fft16_bitrev_reorder against a frame-level queue model.
module tb_fft16_bitrev_reorder;

    localparam int unsigned N = 16;

    logic clk;
    logic rst_n;

    fft16_bitrev_reorder_if #(.N(N)) bus ();

    fft16_bitrev_reorder #(.N(N), .Q(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    // Reference model: completed frames are turned into natural-order samples.
    logic [2*N-1:0] outq[$];
    logic [2*N-1:0] cur[$];
    int pend;
    int rd_idx;
    int n_in;
    int n_out;

    logic           obs_sready, obs_mvalid, obs_mlast;
    logic [N-1:0]   obs_mr, obs_mi;
    logic           exp_sready, exp_mvalid, exp_mlast;
    logic [N-1:0]   exp_mr, exp_mi;
    logic           in_x, out_x;

    function automatic int brev(input int x);
        int r;
        r = 0;
        for (int b = 0; b < 4; b++) begin
            if (((x >> b) & 1) == 1) r = r + (1 << (3 - b));
        end
        return r;
    endfunction

    task automatic model_clear();
        outq.delete();
        cur.delete();
        pend = 0;
        rd_idx = 0;
        n_in = 0;
        n_out = 0;
    endtask

    // Drive one cycle starting at a negedge; sample DUT and model before the posedge.
    task automatic step(input logic sv, input logic [N-1:0] sr, input logic [N-1:0] si,
                        input logic mr);
        bus.s_valid = sv;
        bus.s_r     = sv ? sr : N'($urandom);
        bus.s_i     = sv ? si : N'($urandom);
        bus.m_ready = mr;
        #1;
        obs_sready = bus.s_ready;
        obs_mvalid = bus.m_valid;
        obs_mlast  = bus.m_last;
        obs_mr     = bus.m_r;
        obs_mi     = bus.m_i;
        exp_sready = (pend < 2);
        exp_mvalid = (pend > 0);
        exp_mlast  = exp_mvalid && (rd_idx == 15);
        {exp_mr, exp_mi} = exp_mvalid ? outq[0] : '0;
        in_x  = sv && exp_sready;
        out_x = mr && exp_mvalid;
        if (out_x) begin
            void'(outq.pop_front());
            n_out++;
            rd_idx++;
            if (rd_idx == 16) begin
                rd_idx = 0;
                pend--;
            end
        end
        if (in_x) begin
            cur.push_back({sr, si});
            n_in++;
            if (cur.size() == 16) begin
                for (int k = 0; k < 16; k++) outq.push_back(cur[brev(k)]);
                cur.delete();
                pend++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int cyc);
        rst_n = 1'b0;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        repeat (cyc) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset(3);
        #1;
        checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL reset_sready got %b want 1", bus.s_ready); end
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset_mvalid got %b want 0", bus.m_valid); end
        checks++; if (bus.m_last !== 1'b0) begin errors++; $display("FAIL reset_mlast got %b want 0", bus.m_last); end
        @(negedge clk);
    endtask

    task automatic test_single_frame();
        logic [N-1:0] v;
        logic [N-1:0] want_i;
        int k;
        k = 0;
        for (int c = 0; c < 34; c++) begin
            v = N'(brev(c % 16));
            step(c < 16, v, N'(0) - v, 1'b1);
            checks++;
            if ({obs_sready, obs_mvalid, obs_mlast} !== {exp_sready, exp_mvalid, exp_mlast}) begin
                errors++;
                $display("FAIL single_ctl cyc %0d got %b%b%b want %b%b%b", c, obs_sready,
                         obs_mvalid, obs_mlast, exp_sready, exp_mvalid, exp_mlast);
            end
            checks++;
            if (obs_mvalid !== (c >= 16 && c < 32)) begin
                errors++; $display("FAIL single_latency cyc %0d m_valid got %b", c, obs_mvalid);
            end
            if (out_x) begin
                want_i = N'(0) - N'(k);
                checks++;
                if (obs_mr !== N'(k) || obs_mi !== want_i || obs_mlast !== (k == 15)) begin
                    errors++;
                    $display("FAIL single_data k %0d got %0h/%0h/%b want %0h/%0h/%b", k, obs_mr,
                             obs_mi, obs_mlast, k, want_i, (k == 15));
                end
                k++;
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset(1);
        for (int c = 0; c < 80; c++) begin
            step(c < 64, N'(16 * (c / 16) + brev(c % 16)), N'(c), 1'b1);
            if (c < 64) begin
                checks++;
                if (obs_sready !== 1'b1) begin errors++; $display("FAIL b2b_sready cyc %0d got %b want 1", c, obs_sready); end
            end
            if (c >= 16) begin
                checks++;
                if (obs_mvalid !== 1'b1 || obs_mr !== N'(c - 16)) begin
                    errors++;
                    $display("FAIL b2b_out cyc %0d got v=%b r=%0d want v=1 r=%0d", c, obs_mvalid,
                             obs_mr, c - 16);
                end
                checks++;
                if (obs_mlast !== (((c - 16) % 16) == 15)) begin
                    errors++; $display("FAIL b2b_last cyc %0d got %b", c, obs_mlast);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset(1);
        for (int c = 0; c < 40; c++) begin
            step(1'b1, N'($urandom), N'($urandom), 1'b0);
            checks++;
            if (obs_sready !== (c < 32)) begin
                errors++; $display("FAIL bp_fill_sready cyc %0d got %b want %b", c, obs_sready, c < 32);
            end
        end
        checks++;
        if (n_in !== 32) begin errors++; $display("FAIL bp_accepted got %0d want 32", n_in); end
        for (int d = 0; d < 56; d++) begin
            step(d < 32, N'($urandom), N'($urandom), 1'b1);
            if (d < 32) begin
                checks++;
                if (obs_sready !== (d >= 16)) begin
                    errors++; $display("FAIL bp_drain_sready cyc %0d got %b want %b", d, obs_sready, d >= 16);
                end
            end
            if (out_x) begin
                checks++;
                if ({obs_mr, obs_mi, obs_mlast} !== {exp_mr, exp_mi, exp_mlast}) begin
                    errors++;
                    $display("FAIL bp_data cyc %0d got %0h/%0h/%b want %0h/%0h/%b", d, obs_mr,
                             obs_mi, obs_mlast, exp_mr, exp_mi, exp_mlast);
                end
            end
        end
        checks++;
        if (n_out !== 48) begin errors++; $display("FAIL bp_drained got %0d want 48", n_out); end
    endtask

    task automatic test_random();
        int cyc;
        do_reset(1);
        cyc = 0;
        while (n_out < 1600 && cyc < 30000) begin
            step((n_in < 1600) && ($urandom % 2 == 1), N'($urandom), N'($urandom),
                 ($urandom % 2 == 1));
            cyc++;
            checks++;
            if ({obs_sready, obs_mvalid, obs_mlast} !== {exp_sready, exp_mvalid, exp_mlast}) begin
                errors++;
                $display("FAIL rand_ctl cyc %0d got %b%b%b want %b%b%b", cyc, obs_sready,
                         obs_mvalid, obs_mlast, exp_sready, exp_mvalid, exp_mlast);
            end
            if (out_x) begin
                checks++;
                if ({obs_mr, obs_mi} !== {exp_mr, exp_mi}) begin
                    errors++;
                    $display("FAIL rand_data out %0d got %0h/%0h want %0h/%0h", n_out, obs_mr,
                             obs_mi, exp_mr, exp_mi);
                end
            end
        end
        checks++;
        if (n_out !== 1600) begin errors++; $display("FAIL rand_timeout outputs %0d want 1600", n_out); end
    endtask

    task automatic test_reset_midframe();
        do_reset(1);
        for (int c = 0; c < 7; c++) step(1'b1, N'($urandom), N'($urandom), 1'b0);
        do_reset(1);
        #1;
        checks++;
        if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid got v=%b r=%b want v=0 r=1", bus.m_valid, bus.s_ready);
        end
        @(negedge clk);
        for (int c = 0; c < 32; c++) step(1'b1, N'($urandom), N'($urandom), 1'b0);
        #1;
        checks++;
        if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b1) begin
            errors++; $display("FAIL rst_full got r=%b v=%b want r=0 v=1", bus.s_ready, bus.m_valid);
        end
        @(negedge clk);
        do_reset(1);
        #1;
        checks++;
        if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
            errors++; $display("FAIL rst_both got v=%b r=%b want v=0 r=1", bus.m_valid, bus.s_ready);
        end
        @(negedge clk);
        for (int c = 0; c < 34; c++) begin
            step(c < 16, N'($urandom), N'($urandom), 1'b1);
            if (out_x) begin
                checks++;
                if ({obs_mr, obs_mi, obs_mlast} !== {exp_mr, exp_mi, exp_mlast}) begin
                    errors++;
                    $display("FAIL rst_after_data got %0h/%0h/%b want %0h/%0h/%b", obs_mr, obs_mi,
                             obs_mlast, exp_mr, exp_mi, exp_mlast);
                end
            end
        end
        checks++;
        if (n_out !== 16) begin errors++; $display("FAIL rst_after_count got %0d want 16", n_out); end
    endtask

    task automatic test_extremes();
        logic [N-1:0] v;
        logic [N-1:0] want;
        int k;
        do_reset(1);
        k = 0;
        for (int c = 0; c < 34; c++) begin
            v = (c % 2 == 0) ? 16'h7FFF : 16'h8000;
            step(c < 16, v, ~v, 1'b1);
            if (out_x) begin
                want = (k < 8) ? 16'h7FFF : 16'h8000;
                checks++;
                if (obs_mr !== want || obs_mi !== ~want) begin
                    errors++;
                    $display("FAIL extreme k %0d got %0h/%0h want %0h/%0h", k, obs_mr, obs_mi,
                             want, ~want);
                end
                k++;
            end
        end
        checks++;
        if (k !== 16) begin errors++; $display("FAIL extreme_count got %0d want 16", k); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_r = '0;
        bus.s_i = '0;
        bus.m_ready = 1'b0;
        model_clear();
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_midframe();
        test_extremes();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft16_bitrev_reorder.md
FFT16_BITREV_REORDER -- requirements
Module: fft16_bitrev_reorder

Interface
REQ-001 Parameter N, default 16, sample component width in bits (signed two's complement, real and imaginary each).
REQ-002 Parameter Q, default 8, fractional bits of the fixed-point format; the block carries it unchanged and does no arithmetic on it.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 s_valid  input  1  upstream sample valid.
REQ-006 s_ready  output  1  block can accept a sample this cycle.
REQ-007 s_r / s_i  input  N each  upstream sample, real and imaginary parts, signed.
REQ-008 m_valid  output  1  downstream sample valid.
REQ-009 m_ready  input  1  downstream accepts a sample this cycle.
REQ-010 m_r / m_i  output  N each  downstream sample, real and imaginary parts, signed.
REQ-011 m_last  output  1  high with the 16th (final) sample of each output frame.

Function
REQ-012 The block SHALL accept frames of 16 complex samples from the butterfly datapath in bit-reversed index order and emit them in natural order (0..15).
REQ-013 Storage SHALL be two 16-entry banks (ping-pong) of 2N bits each; one bank fills while the other drains.
REQ-014 An input transfer SHALL occur on a cycle with s_valid && s_ready; an output transfer SHALL occur on a cycle with m_valid && m_ready.
REQ-015 Write side: 4-bit counter wcnt; the sample at wcnt SHALL be stored at address bitrev4(wcnt) of bank wbank, where bitrev4(b3b2b1b0) = b0b1b2b3.
REQ-016 On the input transfer with wcnt==15: wcnt SHALL wrap to 0, full[wbank] SHALL set, and wbank SHALL toggle.
REQ-017 s_ready SHALL equal !full[wbank]; s_ready SHALL NOT depend combinationally on s_valid.
REQ-018 Read side: 4-bit counter rcnt; m_valid SHALL equal full[rbank].
REQ-019 m_r/m_i SHALL present entry rcnt of bank rbank combinationally from the storage array; m_last SHALL equal m_valid && (rcnt==15).
REQ-020 On the output transfer with rcnt==15: rcnt SHALL wrap to 0, full[rbank] SHALL clear, and rbank SHALL toggle.
REQ-021 Latency: m_valid SHALL rise on the cycle after the input transfer of wcnt==15, provided rbank is that bank.
REQ-022 Simultaneous end-of-write-frame and end-of-read-frame on different banks SHALL both take effect in the same cycle; neither event is lost.
REQ-023 With s_valid and m_ready held high continuously, after the first 16-cycle fill the block SHALL sustain one input and one output transfer per cycle with no bubbles.
REQ-024 When both banks are full, s_ready SHALL be 0 and the data held in both banks SHALL remain unchanged until a read frame completes.
REQ-025 Samples SHALL pass bit-exact; the block SHALL NOT scale, round or saturate.
REQ-026 Output data SHALL hold stable while m_valid && !m_ready.
REQ-027 s_r/s_i SHALL be ignored on any cycle without an input transfer.

Reset
REQ-028 When rst_n==0 at a clock edge: wcnt=0, rcnt=0, wbank=0, rbank=0, full[1:0]=0.
REQ-029 Reset outputs: s_ready=1, m_valid=0, m_last=0. m_r/m_i are don't-care while m_valid=0, and the storage array is not reset.
REQ-030 Reset asserted mid-frame SHALL discard all partial and complete frames; the first transfer after reset release SHALL be treated as index 0 of a new frame.

Verification
REQ-031 Single frame, m_ready=1: s_r = 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 (s_i = -s_r) -> m_valid rises the cycle after the 16th transfer; m_r = 0..15, m_i = 0..-15; m_last only on m_r=15.
REQ-032 Back-to-back streaming: 4 frames with s_valid=m_ready=1, values of frame f = 16f + bitrev4(j) -> outputs 0..63 in order, one per cycle after the first 16-cycle fill, s_ready never drops.
REQ-033 Backpressure: m_ready=0 while 3 frames are offered -> s_ready drops after 32 transfers; raising m_ready yields frame 0 then frame 1 intact, and s_ready returns to 1 after frame 0 drains.
REQ-034 Random s_valid/m_ready (50% each), 100 frames of random N-bit values -> scoreboard: each output frame equals its input frame permuted by bitrev4, with no loss, duplication or reordering.
REQ-035 rst_n=0 for 1 cycle after 7 transfers of a frame, and again while both banks are full -> next cycle m_valid=0 and s_ready=1, and a subsequent full frame reorders correctly.
REQ-036 Extreme values: samples 0x7FFF and 0x8000 alternating -> emitted bit-exact at the bit-reversed positions.
